// File: rtl/gyrator_inductor_emu.sv
// Multi-channel discrete-time gyrator (simulated inductor) emulator.
// Two-stage stream pipeline: coefficient multiply, then accumulate/clamp.
module gyrator_inductor_emu #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int K_W        = 16,
  parameter int FRAC_W     = 15,
  parameter int CHANNELS   = 4,
  parameter int LEAK_SHIFT = 8,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]   s_chan,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [K_W-1:0]    cfg_k,
  input  logic              leak_en,
  input  logic              clr,
  input  logic [CH_W-1:0]   clr_chan,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_chan,
  output logic              m_sat
);

  localparam int P_W = DATA_W + K_W;
  localparam int S_W = (ACC_W + 2 > P_W + 1) ? ACC_W + 2 : P_W + 1;

  logic                     advance;
  logic signed [K_W-1:0]    k_q   [CHANNELS];
  logic signed [ACC_W-1:0]  acc_q [CHANNELS];

  logic                     v1;
  logic                     leak1;
  logic                     oor1;
  logic [CH_W-1:0]          c1;
  logic signed [P_W-1:0]    prod1;

  logic                     s_oor;
  logic signed [K_W-1:0]    s_k;
  logic signed [P_W-1:0]    s_mul;
  logic signed [P_W-1:0]    s_prod;

  logic signed [ACC_W-1:0]  acc_cur;
  logic signed [ACC_W-1:0]  leak_amt;
  logic signed [S_W-1:0]    sum;
  logic                     a_ovf;
  logic                     d_ovf;
  logic signed [ACC_W-1:0]  acc_new;
  logic signed [DATA_W-1:0] d_new;
  logic                     wb;

  assign advance = !m_valid || m_ready;
  assign s_ready = advance;
  assign wb      = advance && v1 && !oor1;

  // Stage-1 operand fetch and scaled product (floor via arithmetic shift)
  always_comb begin
    s_oor = 1'b1;
    s_k   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s_chan == CH_W'(i)) begin
        s_oor = 1'b0;
        s_k   = k_q[i];
      end
    end
    s_mul  = P_W'($signed(s_data)) * P_W'(s_k);
    s_prod = s_mul >>> FRAC_W;
  end

  // Stage-2 accumulate with optional leak, then clamp to both ranges
  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (c1 == CH_W'(i)) acc_cur = acc_q[i];
    end
    leak_amt = leak1 ? (acc_cur >>> LEAK_SHIFT) : '0;
    sum = S_W'(acc_cur) + S_W'(prod1) - S_W'(leak_amt);
    a_ovf = !((&sum[S_W-1:ACC_W-1]) || !(|sum[S_W-1:ACC_W-1]));
    d_ovf = !((&sum[S_W-1:DATA_W-1]) || !(|sum[S_W-1:DATA_W-1]));
    if (a_ovf)
      acc_new = sum[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_new = sum[ACC_W-1:0];
    if (d_ovf)
      d_new = sum[S_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                         : {1'b0, {(DATA_W-1){1'b1}}};
    else
      d_new = sum[DATA_W-1:0];
  end

  // Stage-1 register: captures the product so later cfg writes cannot race
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      leak1 <= 1'b0;
      oor1  <= 1'b0;
      c1    <= '0;
      prod1 <= '0;
    end else if (advance) begin
      v1    <= s_valid;
      leak1 <= leak_en;
      oor1  <= s_oor;
      c1    <= s_chan;
      prod1 <= s_prod;
    end
  end

  // Output register; holds while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_sat   <= 1'b0;
    end else if (advance) begin
      m_valid <= v1;
      if (v1) begin
        m_chan <= c1;
        m_data <= oor1 ? '0 : d_new;
        m_sat  <= oor1 ? 1'b0 : (a_ovf || d_ovf);
      end
    end
  end

  // Accumulator write-back; a same-cycle clear takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wb && c1 == CH_W'(i)) acc_q[i] <= acc_new;
        if (clr && clr_chan == CH_W'(i)) acc_q[i] <= '0;
      end
    end
  end

  // Coefficient table, writable regardless of stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) k_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_we && cfg_chan == CH_W'(i)) k_q[i] <= cfg_k;
      end
    end
  end

endmodule

// File: tb/tb_gyrator_inductor_emu.sv
// Directed self-checking bench for gyrator_inductor_emu.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_gyrator_inductor_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [1:0]  s_chan;
  logic        cfg_we;
  logic [1:0]  cfg_chan;
  logic [15:0] cfg_k;
  logic        leak_en;
  logic        clr;
  logic [1:0]  clr_chan;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic        m_sat;

  int n_cmp = 0;
  int n_err = 0;

  gyrator_inductor_emu dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_chan   (s_chan),
    .cfg_we   (cfg_we),
    .cfg_chan (cfg_chan),
    .cfg_k    (cfg_k),
    .leak_en  (leak_en),
    .clr      (clr),
    .clr_chan (clr_chan),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_chan   (m_chan),
    .m_sat    (m_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int k);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_chan = 2'(ch);
    cfg_k    = 16'(k);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic xfer(input string tag, input int ch, input int v,
                      input bit lk, input bit clr_wb,
                      input int exp, input bit exps);
    @(negedge clk);
    chk({tag, "_rdy"}, s_ready, 1);
    s_valid = 1'b1;
    s_chan  = 2'(ch);
    s_data  = 16'(v);
    leak_en = lk;
    @(negedge clk);
    s_valid  = 1'b0;
    leak_en  = 1'b0;
    clr      = clr_wb;
    clr_chan = 2'(ch);
    chk({tag, "_lat"}, m_valid, 0);
    @(negedge clk);
    clr = 1'b0;
    chk({tag, "_vld"}, m_valid, 1);
    chk({tag, "_dat"}, $signed(m_data), exp);
    chk({tag, "_chn"}, m_chan, ch);
    chk({tag, "_sat"}, m_sat, exps);
  endtask

  initial begin
    int sent;
    int got;
    bit saw_stall;
    bit acc_now;
    int rx [4];
    int rc [4];

    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_chan = '0;
    cfg_we = 1'b0; cfg_chan = '0; cfg_k = '0;
    leak_en = 1'b0; clr = 1'b0; clr_chan = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", $signed(m_data), 0);
    chk("rst_mchan", m_chan, 0);
    chk("rst_msat", m_sat, 0);
    chk("rst_sready", s_ready, 1);

    cfg(0, 16'h4000);
    xfer("int0", 0, 1000, 0, 0, 500, 0);
    xfer("int1", 0, 1000, 0, 0, 1000, 0);
    xfer("int2", 0, 1000, 0, 0, 1500, 0);

    cfg(1, 16'h4000);
    xfer("floor", 1, -3, 0, 0, -2, 0);
    xfer("indep", 0, 0, 0, 0, 1500, 0);

    cfg(2, 16'h7FFF);
    xfer("sat0", 2, 32767, 0, 0, 32766, 0);
    xfer("sat1", 2, 32767, 0, 0, 32767, 1);
    xfer("sat2", 2, 32767, 0, 0, 32767, 1);
    xfer("sat3", 2, -32768, 0, 0, 32767, 1);
    xfer("sat4", 2, -32768, 0, 0, 32764, 0);

    cfg(3, 16'h4000);
    xfer("pre0", 3, 25600, 0, 0, 12800, 0);
    xfer("pre1", 3, 25600, 0, 0, 25600, 0);
    xfer("leak0", 3, 0, 1, 0, 25500, 0);
    xfer("leak1", 3, 0, 1, 0, 25401, 0);
    xfer("leak2", 3, 0, 1, 0, 25302, 0);

    xfer("clrwb", 0, 1000, 0, 1, 2000, 0);
    xfer("clrnx", 0, 1000, 0, 0, 500, 0);

    // Backpressure: four samples on chan 1 (acc -2, +1 each)
    sent = 0;
    got = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      m_ready = (c >= 5);
      s_valid = (sent < 4);
      s_chan  = 2'd1;
      s_data  = 16'd2;
      #1;
      if (!s_ready) saw_stall = 1'b1;
      if (m_valid && !m_ready) begin
        chk("bp_hold_d", $signed(m_data), -1);
        chk("bp_hold_c", m_chan, 1);
      end
      if (m_valid && m_ready) begin
        rx[got] = int'($signed(m_data));
        rc[got] = int'(m_chan);
        got++;
      end
      acc_now = s_valid && s_ready;
      @(posedge clk);
      if (acc_now) sent++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("bp_stall", saw_stall, 1);
    chk("bp_count", got, 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", rx[i], i - 1);
      chk("bp_chan", rc[i], 1);
    end
    repeat (3) begin
      @(negedge clk);
      chk("bp_nodup", m_valid, 0);
    end

    // Async reset with samples in flight
    @(negedge clk);
    s_valid = 1'b1; s_chan = 2'd0; s_data = 16'd1000;
    @(negedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid_vld", m_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", m_valid, 0);
    chk("mid_rst_dat", $signed(m_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush", m_valid, 0);
    end
    for (int ch = 0; ch < 4; ch++) begin
      xfer("acc0", ch, 1000, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
